// File: rtl/seg_disp_arbiter.sv
// Round-robin arbiter sharing one 7-segment display among N_REQ value sources.
// A granted source holds the display for HOLD ticks, can be preempted after MIN_HOLD.
module seg_disp_arbiter #(
    parameter int N_REQ    = 4,
    parameter int TICK_MOD = 50000,
    parameter int HOLD     = 2000,
    parameter int MIN_HOLD = 300,
    parameter int DEF_CH   = 0
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [N_REQ-1:0]     REQ,
    input  logic [8*N_REQ-1:0]   DATA_IN,
    output logic [7:0]           BIN_OUT,
    output logic [N_REQ-1:0]     GNT,
    output logic [2:0]           SRC,
    output logic                 ACTIVE
);

    localparam int TICK_W = (TICK_MOD > 1) ? $clog2(TICK_MOD) : 1;
    localparam int HOLD_W = $clog2(HOLD + 1);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t             state, state_n;
    logic [N_REQ-1:0]   pending, pending_n;
    logic [2:0]         rr_last;
    logic [TICK_W-1:0]  tick_cnt;
    logic [HOLD_W-1:0]  hold_cnt, hold_n;
    logic [N_REQ-1:0]   gnt_n;
    logic [2:0]         src_n;
    logic               act_n;
    logic [7:0]         bin_n;
    logic               tick;
    logic [N_REQ-1:0]   cand;
    logic [N_REQ-1:0]   sel_oh;
    logic [2:0]         sel_idx;
    logic               grant, restart, to_idle;

    // Nearest set bit of m strictly after 'last', wrapping around.
    function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] m,
                                                 input logic [2:0] last);
        logic [N_REQ-1:0] oh;
        int best;
        int d;
        oh   = '0;
        best = N_REQ;
        for (int i = 0; i < N_REQ; i++) begin
            d = (i + N_REQ - 1 - int'(last)) % N_REQ;
            if (m[i] && d < best) begin
                best  = d;
                oh    = '0;
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

    function automatic logic [2:0] oh2idx(input logic [N_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    assign tick    = (tick_cnt == TICK_W'(TICK_MOD - 1));
    assign cand    = (state == IDLE) ? (REQ | pending) : pending;
    assign sel_oh  = rr_pick(cand, rr_last);
    assign sel_idx = oh2idx(sel_oh);

    always_comb begin
        state_n = state;
        gnt_n   = GNT;
        src_n   = SRC;
        act_n   = ACTIVE;
        grant   = 1'b0;
        restart = 1'b0;
        to_idle = 1'b0;

        case (state)
            IDLE: begin
                if (|cand) grant = 1'b1;
            end
            SHOW: begin
                // Re-request by the owner wins over both preemption and expiry.
                if (|(REQ & GNT)) begin
                    restart = 1'b1;
                end else if (hold_cnt >= HOLD_W'(MIN_HOLD) && |pending) begin
                    grant = 1'b1;
                end else if (hold_cnt == HOLD_W'(HOLD)) begin
                    if (|pending) grant = 1'b1;
                    else          to_idle = 1'b1;
                end
            end
            default: to_idle = 1'b1;
        endcase

        if (grant) begin
            state_n = SHOW;
            gnt_n   = sel_oh;
            src_n   = sel_idx;
            act_n   = 1'b1;
        end else if (to_idle) begin
            state_n = IDLE;
            gnt_n   = '0;
            src_n   = 3'(DEF_CH);
            act_n   = 1'b0;
        end
    end

    always_comb begin
        pending_n = pending | (REQ & ((state == SHOW) ? ~GNT : '1));
        if (grant) pending_n = pending_n & ~sel_oh;

        hold_n = hold_cnt;
        if (grant || restart)
            hold_n = '0;
        else if (state == SHOW && tick && hold_cnt != HOLD_W'(HOLD))
            hold_n = hold_cnt + HOLD_W'(1);

        bin_n = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (SRC == 3'(i)) bin_n = DATA_IN[8*i +: 8];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= IDLE;
            pending  <= '0;
            rr_last  <= 3'(N_REQ - 1);
            tick_cnt <= '0;
            hold_cnt <= '0;
            GNT      <= '0;
            SRC      <= 3'(DEF_CH);
            ACTIVE   <= 1'b0;
            BIN_OUT  <= '0;
        end else begin
            state    <= state_n;
            pending  <= pending_n;
            tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
            hold_cnt <= hold_n;
            GNT      <= gnt_n;
            SRC      <= src_n;
            ACTIVE   <= act_n;
            BIN_OUT  <= bin_n;
            if (grant) rr_last <= sel_idx;
        end
    end

endmodule
